ad_rr_dispatch_ctrl: RTL and testbench

// Dispatch controller between the per-switch frame FIFOs and the switch bus of the address decoder.
// - Arbitrates round-robin among non-empty FIFOs and pops the granted frame.
// - Drives one switch transaction at a time and waits for that switch's ack.
// - Reports completion: op_id plus read data, or a timeout error.

---
 rtl/ad_rr_dispatch_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ad_rr_dispatch_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_rr_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ad_rr_dispatch_ctrl
// Description : Round-robin dispatch controller between the per-switch frame
//               FIFOs and the switch bus of the address decoder. It picks one
//               non-empty FIFO, pops its head frame, runs a single switch
//               transaction and reports completion or a timeout.
// Ports       : clk, rst_n         - clock / synchronous active-low reset
//               enable_in          - allows new grants
//               empty_in, frame_in - FIFO empty flags and FWFT head frames
//               ack_in, rd_data_in - per-switch ack and shared read data
//               fifo_rd_en         - one-hot pop pulse (ISSUE cycle only)
//               sel_en_out, addr_out, wr_data_out, wr_rd_s_out - switch bus
//               busy_out           - controller not idle
//               done_valid, done_op_id, rd_data_out, timeout_err - completion
// Revision    : 1.0 - initial release
// ============================================================================
module ad_rr_dispatch_ctrl #(
    parameter int NUM_SW_INST    = 5,
    parameter int W_WIDTH        = 8,
    parameter int FRAME_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable_in,
    input  logic [NUM_SW_INST-1:0]             empty_in,
    input  logic [FRAME_WIDTH*NUM_SW_INST-1:0] frame_in,
    input  logic [NUM_SW_INST-1:0]             ack_in,
    input  logic [W_WIDTH-1:0]                 rd_data_in,
    output logic [NUM_SW_INST-1:0]             fifo_rd_en,
    output logic [NUM_SW_INST-1:0]             sel_en_out,
    output logic [W_WIDTH-1:0]                 addr_out,
    output logic [W_WIDTH-1:0]                 wr_data_out,
    output logic                               wr_rd_s_out,
    output logic                               busy_out,
    output logic                               done_valid,
    output logic [7:0]                         done_op_id,
    output logic [W_WIDTH-1:0]                 rd_data_out,
    output logic                               timeout_err
);

    localparam int c_IDX_W     = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
    localparam int c_CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam int c_OP_MSB    = FRAME_WIDTH - 1;
    localparam int c_ADDR_MSB  = FRAME_WIDTH - 9;
    localparam int c_WDATA_MSB = FRAME_WIDTH - 9 - W_WIDTH;

    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDX_W:0]       c_NUM      = (c_IDX_W + 1)'(NUM_SW_INST);
    localparam logic [c_IDX_W-1:0]     c_IDX_LAST = c_IDX_W'(NUM_SW_INST - 1);
    localparam logic [NUM_SW_INST-1:0] c_ONE      = NUM_SW_INST'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_grant;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_op_id;

    logic [FRAME_WIDTH-1:0] w_frames [NUM_SW_INST];
    logic [FRAME_WIDTH-1:0] w_frame;
    logic [c_IDX_W:0]       w_sum;
    logic [c_IDX_W-1:0]     w_idx;
    logic [c_IDX_W-1:0]     w_grant;
    logic                   w_found;
    logic [NUM_SW_INST-1:0] w_onehot;
    logic [c_IDX_W-1:0]     w_next_ptr;
    logic                   w_ack_hit;
    logic                   w_unused_bits;

    // Split the flat frame bus into one head frame per FIFO.
    generate
        for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_slice
            assign w_frames[gi] = frame_in[gi*FRAME_WIDTH +: FRAME_WIDTH];
        end
    endgenerate

    // Scan from rr_ptr upwards (modulo N) for the first non-empty FIFO.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SW_INST; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_idx = w_sum[c_IDX_W-1:0];
            if (!w_found && !empty_in[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_frame = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (w_grant == c_IDX_W'(i)) begin
                w_frame = w_frames[i];
            end
        end
    end

    assign w_onehot   = c_ONE << w_grant;
    assign w_next_ptr = (r_grant == c_IDX_LAST) ? '0 : r_grant + c_IDX_W'(1);
    // sel_en_out holds the granted switch one-hot, so it masks foreign acks.
    assign w_ack_hit  = |(ack_in & sel_en_out);
    // Frame bits between wr_data and wr_rd carry no meaning for this block.
    assign w_unused_bits = ^w_frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_op_id     <= '0;
            fifo_rd_en  <= '0;
            sel_en_out  <= '0;
            addr_out    <= '0;
            wr_data_out <= '0;
            wr_rd_s_out <= 1'b0;
            busy_out    <= 1'b0;
            done_valid  <= 1'b0;
            done_op_id  <= '0;
            rd_data_out <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_in && w_found) begin
                        // Outputs for the ISSUE cycle are loaded here so that
                        // they are visible exactly while the FSM is in ISSUE.
                        r_state     <= S_ISSUE;
                        r_grant     <= w_grant;
                        r_op_id     <= w_frame[c_OP_MSB -: 8];
                        fifo_rd_en  <= w_onehot;
                        sel_en_out  <= w_onehot;
                        addr_out    <= w_frame[c_ADDR_MSB -: W_WIDTH];
                        wr_data_out <= w_frame[c_WDATA_MSB -: W_WIDTH];
                        wr_rd_s_out <= w_frame[0];
                        busy_out    <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    fifo_rd_en <= '0;
                    r_cnt      <= '0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_ack_hit || (r_cnt == c_CNT_LAST)) begin
                        // Ack is tested first so it wins on the last cycle.
                        done_valid  <= 1'b1;
                        done_op_id  <= r_op_id;
                        timeout_err <= !w_ack_hit;
                        rd_data_out <= (w_ack_hit && !wr_rd_s_out) ? rd_data_in : '0;
                        sel_en_out  <= '0;
                        addr_out    <= '0;
                        wr_data_out <= '0;
                        wr_rd_s_out <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_cnt       <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done_valid  <= 1'b0;
                    done_op_id  <= '0;
                    rd_data_out <= '0;
                    timeout_err <= 1'b0;
                    busy_out    <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad_rr_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_rr_dispatch_ctrl
// Description : Self-checking bench for ad_rr_dispatch_ctrl. FIFOs are modelled
//               as queues; grants, completions and timeouts are predicted from
//               a round-robin pointer kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_rr_dispatch_ctrl;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int FW = 32;
    localparam int T  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable_in;
    logic [N-1:0]      empty_in;
    logic [FW*N-1:0]   frame_in;
    logic [N-1:0]      ack_in;
    logic [W-1:0]      rd_data_in;
    logic [N-1:0]      fifo_rd_en;
    logic [N-1:0]      sel_en_out;
    logic [W-1:0]      addr_out;
    logic [W-1:0]      wr_data_out;
    logic              wr_rd_s_out;
    logic              busy_out;
    logic              done_valid;
    logic [7:0]        done_op_id;
    logic [W-1:0]      rd_data_out;
    logic              timeout_err;

    always #5 clk = ~clk;

    ad_rr_dispatch_ctrl #(
        .NUM_SW_INST    (N),
        .W_WIDTH        (W),
        .FRAME_WIDTH    (FW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_in   (enable_in),
        .empty_in    (empty_in),
        .frame_in    (frame_in),
        .ack_in      (ack_in),
        .rd_data_in  (rd_data_in),
        .fifo_rd_en  (fifo_rd_en),
        .sel_en_out  (sel_en_out),
        .addr_out    (addr_out),
        .wr_data_out (wr_data_out),
        .wr_rd_s_out (wr_rd_s_out),
        .busy_out    (busy_out),
        .done_valid  (done_valid),
        .done_op_id  (done_op_id),
        .rd_data_out (rd_data_out),
        .timeout_err (timeout_err)
    );

    logic [FW-1:0] q [N][$];
    int            rr;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] make_frame(input logic [7:0] op, input logic [7:0] addr,
                                                 input logic [7:0] data, input logic wr,
                                                 input logic [6:0] junk);
        return {op, addr, data, junk, wr};
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            if (q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < N; i++) begin
            empty_in[i] = (q[i].size() == 0);
            frame_in[i*FW +: FW] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rd_en"},   32'(fifo_rd_en),  32'd0);
        chk({pfx, "_sel_en"},  32'(sel_en_out),  32'd0);
        chk({pfx, "_addr"},    32'(addr_out),    32'd0);
        chk({pfx, "_wdata"},   32'(wr_data_out), 32'd0);
        chk({pfx, "_wr_rd"},   32'(wr_rd_s_out), 32'd0);
        chk({pfx, "_busy"},    32'(busy_out),    32'd0);
        chk({pfx, "_done"},    32'(done_valid),  32'd0);
        chk({pfx, "_op_id"},   32'(done_op_id),  32'd0);
        chk({pfx, "_rdata"},   32'(rd_data_out), 32'd0);
        chk({pfx, "_tmo"},     32'(timeout_err), 32'd0);
    endtask

    // One full transaction, starting in IDLE with work queued and enable high.
    // ack_delay = index of the WAIT cycle carrying ack; >= T means no ack.
    task automatic run_txn(input int ack_delay, input logic [7:0] rdata,
                           input logic [N-1:0] noise, output int g);
        logic [FW-1:0] f;
        logic [N-1:0]  oh;
        logic          acked;
        logic [7:0]    exp_rd;
        g = model_pick();
        if (g < 0) begin
            failures++;
            $display("FAIL txn_precondition observed=no_frame expected=frame_queued");
            return;
        end
        f  = q[g][0];
        oh = N'(1) << g;

        tick();  // ISSUE
        chk("issue_rd_en", 32'(fifo_rd_en),  32'(oh));
        chk("issue_sel",   32'(sel_en_out),  32'(oh));
        chk("issue_addr",  32'(addr_out),    32'(f[23:16]));
        chk("issue_wdata", 32'(wr_data_out), 32'(f[15:8]));
        chk("issue_wr_rd", 32'(wr_rd_s_out), 32'(f[0]));
        chk("issue_busy",  32'(busy_out),    32'd1);
        chk("issue_done",  32'(done_valid),  32'd0);
        void'(q[g].pop_front());
        drive_fifos();
        ack_in     = noise;  // ignored during ISSUE, even the granted bit
        rd_data_in = 8'($urandom);

        acked = 1'b0;
        for (int w = 0; w < T; w++) begin
            tick();  // WAIT cycle w
            chk("wait_sel",   32'(sel_en_out),  32'(oh));
            chk("wait_rd_en", 32'(fifo_rd_en),  32'd0);
            chk("wait_addr",  32'(addr_out),    32'(f[23:16]));
            chk("wait_done",  32'(done_valid),  32'd0);
            if (w == ack_delay) begin
                ack_in     = (noise & ~oh) | oh;
                rd_data_in = rdata;
                acked      = 1'b1;
            end else begin
                ack_in     = noise & ~oh;
                rd_data_in = 8'($urandom);
            end
            if (acked) break;
        end

        tick();  // DONE
        ack_in = '0;
        exp_rd = (acked && !f[0]) ? rdata : 8'h00;
        chk("done_valid", 32'(done_valid),  32'd1);
        chk("done_op_id", 32'(done_op_id),  32'(f[31:24]));
        chk("done_rdata", 32'(rd_data_out), 32'(exp_rd));
        chk("done_tmo",   32'(timeout_err), 32'(!acked));
        chk("done_sel",   32'(sel_en_out),  32'd0);
        chk("done_addr",  32'(addr_out),    32'd0);
        chk("done_wdata", 32'(wr_data_out), 32'd0);
        chk("done_wr_rd", 32'(wr_rd_s_out), 32'd0);
        chk("done_busy",  32'(busy_out),    32'd1);
        rr = (g + 1) % N;

        tick();  // IDLE
        chk("idle_done",  32'(done_valid),  32'd0);
        chk("idle_busy",  32'(busy_out),    32'd0);
        chk("idle_op_id", 32'(done_op_id),  32'd0);
        chk("idle_rdata", 32'(rd_data_out), 32'd0);
        chk("idle_tmo",   32'(timeout_err), 32'd0);
    endtask

    initial begin
        int g;
        int rr_exp [6];
        rr_exp = '{0, 1, 4, 0, 1, 4};

        rst_n      = 1'b0;
        enable_in  = 1'b0;
        ack_in     = '0;
        rd_data_in = '0;
        rr         = 0;
        drive_fifos();
        tick();
        tick();
        chk_all_zero("reset");
        rst_n     = 1'b1;
        enable_in = 1'b1;
        tick();
        chk("idle_empty_busy", 32'(busy_out), 32'd0);

        // Write on FIFO2, ack on the third WAIT cycle.
        q[2].push_back(make_frame(8'h11, 8'h40, 8'hA5, 1'b1, 7'h00));
        drive_fifos();
        run_txn(2, 8'h5A, '0, g);
        chk("write_grant", 32'(g), 32'd2);

        // Read on FIFO0, immediate ack with data.
        q[0].push_back(make_frame(8'h22, 8'h10, 8'h00, 1'b0, 7'h00));
        drive_fifos();
        run_txn(0, 8'h3C, '0, g);
        chk("read_grant", 32'(g), 32'd0);

        // Round-robin from a fresh reset: FIFOs 0,1,4 with two frames each.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rr    = 0;
        for (int k = 0; k < 2; k++) begin
            q[0].push_back(make_frame(8'h30 + 8'(k), 8'h01, 8'h02, 1'b0, 7'h55));
            q[1].push_back(make_frame(8'h40 + 8'(k), 8'h03, 8'h04, 1'b1, 7'h2A));
            q[4].push_back(make_frame(8'h50 + 8'(k), 8'h05, 8'h06, 1'b0, 7'h7F));
        end
        drive_fifos();
        for (int k = 0; k < 6; k++) begin
            run_txn(0, 8'(8'h90 + k), '0, g);
            chk("rr_order", 32'(g), 32'(rr_exp[k]));
        end

        // Timeout on FIFO3 with a stray ack on switch 1.
        q[3].push_back(make_frame(8'h33, 8'h77, 8'h88, 1'b0, 7'h00));
        drive_fifos();
        run_txn(T + 5, 8'hEE, 5'b00010, g);
        chk("timeout_grant", 32'(g), 32'd3);

        // Ack on the very last WAIT cycle wins over the timeout.
        q[3].push_back(make_frame(8'h34, 8'h78, 8'h00, 1'b0, 7'h00));
        drive_fifos();
        run_txn(T - 1, 8'h77, '0, g);
        chk("late_ack_grant", 32'(g), 32'd3);

        // enable_in low blocks grants even with work queued.
        enable_in = 1'b0;
        q[1].push_back(make_frame(8'h61, 8'h11, 8'h22, 1'b1, 7'h00));
        q[2].push_back(make_frame(8'h62, 8'h33, 8'h44, 1'b0, 7'h00));
        drive_fifos();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("disabled_busy",  32'(busy_out),   32'd0);
            chk("disabled_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        enable_in = 1'b1;
        run_txn(1, 8'h00, '0, g);
        chk("reenable_grant1", 32'(g), 32'd1);
        run_txn(3, 8'hC3, '0, g);
        chk("reenable_grant2", 32'(g), 32'd2);

        // Reset in the middle of WAIT: transaction dropped, pointer back to 0.
        q[2].push_back(make_frame(8'h70, 8'h12, 8'h34, 1'b0, 7'h00));
        drive_fifos();
        tick();
        chk("abort_issue_rd_en", 32'(fifo_rd_en), 32'b00100);
        void'(q[2].pop_front());
        drive_fifos();
        tick();
        tick();
        chk("abort_wait_sel", 32'(sel_en_out), 32'b00100);
        rst_n = 1'b0;
        tick();
        chk_all_zero("abort_reset");
        q[0].push_back(make_frame(8'h80, 8'h21, 8'h43, 1'b0, 7'h00));
        q[4].push_back(make_frame(8'h84, 8'h65, 8'h87, 1'b1, 7'h00));
        drive_fifos();
        tick();
        chk("abort_reset_done", 32'(done_valid), 32'd0);
        rst_n = 1'b1;
        rr    = 0;
        run_txn(0, 8'hA1, '0, g);
        chk("restart_grant", 32'(g), 32'd0);
        run_txn(0, 8'hA2, '0, g);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 40; n++) begin
            int  pushes;
            int  dly;
            bit  any;
            pushes = $urandom_range(0, 2);
            for (int p = 0; p < pushes; p++) begin
                int f;
                f = $urandom_range(0, N - 1);
                if (q[f].size() < 4)
                    q[f].push_back(make_frame(8'($urandom), 8'($urandom), 8'($urandom),
                                              1'($urandom), 7'($urandom)));
            end
            any = 1'b0;
            for (int i = 0; i < N; i++) if (q[i].size() > 0) any = 1'b1;
            if (!any)
                q[$urandom_range(0, N - 1)].push_back(make_frame(8'($urandom), 8'($urandom),
                                                   8'($urandom), 1'($urandom), 7'($urandom)));
            drive_fifos();
            if ($urandom_range(0, 4) == 0) begin
                enable_in = 1'b0;
                repeat (3) begin
                    tick();
                    chk("rnd_disabled_busy", 32'(busy_out), 32'd0);
                end
                enable_in = 1'b1;
            end
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(T, T + 4) : $urandom_range(0, T - 1);
            run_txn(dly, 8'($urandom), N'($urandom), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
